// File: rtl/pong_pkg.sv
// pong_pkg: shared widths, state encoding and default geometry for the Pong ball engine
package pong_pkg;
  localparam int COORD_W = 10;
  localparam int EXT_W = COORD_W + 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_BALL_SIZE = 10;
  localparam int DEF_PADDLE_LEN = 50;
  localparam int DEF_PADDLE_W = 5;
  localparam int DEF_P1_X = 30;
  localparam int DEF_P2_X = 600;
  function automatic logic [COORD_W-1:0] centre(input int res, input int size);
    return COORD_W'((res - size) / 2);
  endfunction
endpackage

// File: rtl/pong_axis_step.sv
// pong_axis_step: one-axis move by speed, clamping and reversing when the leading edge reaches an enabled limit
module pong_axis_step
  import pong_pkg::*;
(
  input  logic [COORD_W-1:0] i_pos,
  input  logic               i_dir,
  input  logic [COORD_W-1:0] i_speed,
  input  logic [COORD_W-1:0] i_lo_edge,
  input  logic [COORD_W-1:0] i_lo_pos,
  input  logic               i_lo_en,
  input  logic [COORD_W-1:0] i_hi_edge,
  input  logic [COORD_W-1:0] i_hi_pos,
  input  logic               i_hi_en,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_dir
);
  logic [EXT_W-1:0]   w_ahead;
  logic [COORD_W-1:0] w_step;
  logic               w_lo_hit;
  logic               w_hi_hit;
  // limits are compared against pos+speed so nothing is subtracted before the test
  assign w_ahead = {1'b0, i_pos} + {1'b0, i_speed};
  assign w_lo_hit = i_lo_en && !i_dir && ({1'b0, i_pos} <= {1'b0, i_lo_edge} + {1'b0, i_speed});
  assign w_hi_hit = i_hi_en && i_dir && (w_ahead >= {1'b0, i_hi_edge});
  assign w_step = i_dir ? w_ahead[COORD_W-1:0] : (i_pos > i_speed ? i_pos - i_speed : '0);
  assign o_pos = w_lo_hit ? i_lo_pos : w_hi_hit ? i_hi_pos : w_step;
  assign o_dir = (w_lo_hit || w_hi_hit) ? !i_dir : i_dir;
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball motion, wall/paddle bounces, misses, scoring and the serve/play/over state machine.
// Define PONG_SPEEDUP_EN to raise speed by one per paddle hit, capped at MAX_SPEED.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_LEN   = DEF_PADDLE_LEN,
  parameter int PADDLE_W     = DEF_PADDLE_W,
  parameter int P1_X         = DEF_P1_X,
  parameter int P2_X         = DEF_P2_X,
  parameter int BASE_SPEED   = 1,
  parameter int MAX_SPEED    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic [COORD_W-1:0] paddle_one_y,
  input  logic [COORD_W-1:0] paddle_two_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               collided,
  output logic               missed,
  output logic [SCORE_W-1:0] score_one,
  output logic [SCORE_W-1:0] score_two,
  output logic               game_over,
  output logic [1:0]         state
);
`ifdef PONG_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [COORD_W-1:0] CX = centre(H_RES, BALL_SIZE);
  localparam logic [COORD_W-1:0] CY = centre(V_RES, BALL_SIZE);
  localparam logic [COORD_W-1:0] X_LO_EDGE = COORD_W'(P1_X + PADDLE_W - 1);
  localparam logic [COORD_W-1:0] X_LO_POS = COORD_W'(P1_X + PADDLE_W);
  localparam logic [COORD_W-1:0] X_HI_EDGE = COORD_W'(P2_X - BALL_SIZE + 1);
  localparam logic [COORD_W-1:0] X_HI_POS = COORD_W'(P2_X - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [EXT_W-1:0]   X_MISS = EXT_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] SPD0 = COORD_W'(BASE_SPEED);
  localparam logic [COORD_W-1:0] SPD_TOP = COORD_W'(SPEEDUP ? MAX_SPEED : BASE_SPEED);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_dir_x;
  logic               r_dir_y;
  logic [COORD_W-1:0] r_speed;
  logic [SCORE_W-1:0] r_score_one;
  logic [SCORE_W-1:0] r_score_two;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_collided;
  logic               r_missed;
  logic               w_ov1;
  logic               w_ov2;
  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;
  logic               w_ndx;
  logic               w_ndy;
  logic               w_hit;
  logic               w_miss_r;
  logic               w_miss_l;
  logic [SCORE_W-1:0] w_s1_inc;
  logic [SCORE_W-1:0] w_s2_inc;
  assign w_ov1 = ({1'b0, r_y} + EXT_W'(BALL_SIZE - 1) >= {1'b0, paddle_one_y})
              && ({1'b0, r_y} <= {1'b0, paddle_one_y} + EXT_W'(PADDLE_LEN - 1));
  assign w_ov2 = ({1'b0, r_y} + EXT_W'(BALL_SIZE - 1) >= {1'b0, paddle_two_y})
              && ({1'b0, r_y} <= {1'b0, paddle_two_y} + EXT_W'(PADDLE_LEN - 1));
  pong_axis_step u_x (
    .i_pos     (r_x),
    .i_dir     (r_dir_x),
    .i_speed   (r_speed),
    .i_lo_edge (X_LO_EDGE),
    .i_lo_pos  (X_LO_POS),
    .i_lo_en   (w_ov1),
    .i_hi_edge (X_HI_EDGE),
    .i_hi_pos  (X_HI_POS),
    .i_hi_en   (w_ov2),
    .o_pos     (w_nx),
    .o_dir     (w_ndx)
  );
  pong_axis_step u_y (
    .i_pos     (r_y),
    .i_dir     (r_dir_y),
    .i_speed   (r_speed),
    .i_lo_edge ('0),
    .i_lo_pos  ('0),
    .i_lo_en   (1'b1),
    .i_hi_edge (Y_HI),
    .i_hi_pos  (Y_HI),
    .i_hi_en   (1'b1),
    .o_pos     (w_ny),
    .o_dir     (w_ndy)
  );
  // X direction only ever reverses on a paddle hit
  assign w_hit = w_ndx ^ r_dir_x;
  assign w_miss_r = r_dir_x && !w_hit && ({1'b0, r_x} + {1'b0, r_speed} >= X_MISS);
  assign w_miss_l = !r_dir_x && !w_hit && (r_x <= r_speed);
  assign w_s1_inc = (&r_score_one) ? r_score_one : r_score_one + SCORE_W'(1);
  assign w_s2_inc = (&r_score_two) ? r_score_two : r_score_two + SCORE_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= CX;
      r_y <= CY;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b1;
      r_speed <= SPD0;
      r_score_one <= '0;
      r_score_two <= '0;
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_collided <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_collided <= 1'b0;
      r_missed <= 1'b0;
      case (r_state)
        ST_IDLE: if (serve) begin
          r_state <= ST_SERVE;
          r_cnt <= '0;
        end
        ST_SERVE: if (frame_tick) begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= ST_PLAY;
        end
        ST_PLAY: if (frame_tick) begin
          if (w_miss_r || w_miss_l) begin
            r_x <= CX;
            r_y <= CY;
            r_speed <= SPD0;
            r_dir_x <= w_miss_r;
            r_missed <= 1'b1;
            r_cnt <= '0;
            r_score_one <= w_miss_r ? w_s1_inc : r_score_one;
            r_score_two <= w_miss_l ? w_s2_inc : r_score_two;
            r_state <= ((w_miss_r ? w_s1_inc : w_s2_inc) == WIN) ? ST_OVER : ST_SERVE;
          end else begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_dir_x <= w_ndx;
            r_dir_y <= w_ndy;
            r_collided <= w_hit;
            if (w_hit && r_speed < SPD_TOP) r_speed <= r_speed + COORD_W'(1);
          end
        end
        default: if (serve) begin
          r_score_one <= '0;
          r_score_two <= '0;
          r_state <= ST_SERVE;
          r_cnt <= '0;
        end
      endcase
    end
  end
  assign ball_x = r_x;
  assign ball_y = r_y;
  assign collided = r_collided;
  assign missed = r_missed;
  assign score_one = r_score_one;
  assign score_two = r_score_two;
  assign game_over = (r_state == ST_OVER);
  assign state = r_state;
endmodule
